// File: rtl/msrh_pkg.sv
// -----------------------------------------------------------------------------
// msrh_pkg
// Shared types and default sizing for the L1D external-port arbiter.
//   ext_cmd_t          : external command encoding (load / store-writeback)
//   l1d_ext_arb_req_t  : one requester's request fields at default sizing
//   ext_resp_t         : one external response at default sizing
//   EXT_SRC_W          : width of the source-id prefix carried in the tag
//   EXT_MAX_OUTSTANDING: default in-flight transaction bound
// -----------------------------------------------------------------------------
package msrh_pkg;

    localparam int EXT_REQ_NUM         = 3;
    localparam int EXT_PADDR_W         = 56;
    localparam int EXT_LINE_W          = 512;
    localparam int EXT_TAG_W           = 4;
    localparam int EXT_SRC_W           = $clog2(EXT_REQ_NUM);
    localparam int EXT_MAX_OUTSTANDING = 8;

    typedef enum logic {
        EXT_LOAD  = 1'b0,
        EXT_STORE = 1'b1
    } ext_cmd_t;

    typedef struct packed {
        ext_cmd_t                cmd;
        logic [EXT_PADDR_W-1:0]  paddr;
        logic [EXT_TAG_W-1:0]    tag;
        logic [EXT_LINE_W-1:0]   data;
    } l1d_ext_arb_req_t;

    typedef struct packed {
        logic [EXT_SRC_W+EXT_TAG_W-1:0] tag;
        logic [EXT_LINE_W-1:0]          data;
    } ext_resp_t;

endpackage

// File: rtl/msrh_rr_arbiter.sv
// -----------------------------------------------------------------------------
// msrh_rr_arbiter
// Round-robin arbiter: the first requester at or after the pointer wins.
// The pointer moves to (winner + 1) mod WIDTH only when the grant is used.
//   i_clk, i_reset : clock, asynchronous active-high reset (pointer -> 0)
//   i_req          : request vector
//   i_en           : grant is consumed this cycle, advance pointer
//   o_grant        : one-hot grant (zero when no request)
// -----------------------------------------------------------------------------
module msrh_rr_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_req,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_grant
);

    localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int         sum;
        logic [PTR_W-1:0] idx;
        logic       found;
        o_grant = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        // Scan WIDTH positions starting at the pointer, wrapping once.
        for (int k = 0; k < WIDTH; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= WIDTH) sum = sum - WIDTH;
            idx = PTR_W'(sum);
            if (!found && i_req[idx]) begin
                found        = 1'b1;
                o_grant[idx] = 1'b1;
                ptr_d        = (sum + 1 == WIDTH) ? '0 : PTR_W'(sum + 1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   ptr_q <= '0;
        else if (i_en) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/msrh_l1d_ext_arbiter.sv
// -----------------------------------------------------------------------------
// msrh_l1d_ext_arbiter
// Shares the single L1D external (L2-side) request port among REQ_NUM miss
// sources (0 = load, then store-miss, eviction writeback). Round-robin pick
// into one registered output slot, bounded in-flight count, and responses
// routed back to their source by the source-id prefix of the echoed tag.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req_* / o_req_ready   per-source request handshake (ready one-hot or 0)
//   o_ext_* / i_ext_ready   external request port (held stable until ready)
//   i_resp_*                external response (tag = {source id, local tag})
//   o_resp_*                one-hot response to the owning source
//   o_outstanding           transactions in the slot or awaiting response
//   o_resp_err              sticky: response with no outstanding work or a
//                           source id >= REQ_NUM
// Optional (macro MSRH_EXT_ARB_PERF_EN):
//   o_perf_grant_cnt        per-source accepted-request count, wrapping
//   o_perf_stall_cnt        cycles with o_ext_valid & !i_ext_ready, wrapping
// -----------------------------------------------------------------------------
module msrh_l1d_ext_arbiter
    import msrh_pkg::*;
#(
    parameter  int REQ_NUM         = EXT_REQ_NUM,
    parameter  int PADDR_W         = EXT_PADDR_W,
    parameter  int LINE_W          = EXT_LINE_W,
    parameter  int TAG_W           = EXT_TAG_W,
    parameter  int MAX_OUTSTANDING = EXT_MAX_OUTSTANDING,
    localparam int SRC_W           = $clog2(REQ_NUM),
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [REQ_NUM-1:0]                i_req_valid,
    output logic [REQ_NUM-1:0]                o_req_ready,
    input  logic [REQ_NUM-1:0]                i_req_cmd,
    input  logic [REQ_NUM-1:0][PADDR_W-1:0]   i_req_paddr,
    input  logic [REQ_NUM-1:0][TAG_W-1:0]     i_req_tag,
    input  logic [REQ_NUM-1:0][LINE_W-1:0]    i_req_data,
    output logic                              o_ext_valid,
    input  logic                              i_ext_ready,
    output logic                              o_ext_cmd,
    output logic [PADDR_W-1:0]                o_ext_paddr,
    output logic [SRC_W+TAG_W-1:0]            o_ext_tag,
    output logic [LINE_W-1:0]                 o_ext_data,
    input  logic                              i_resp_valid,
    input  logic [SRC_W+TAG_W-1:0]            i_resp_tag,
    input  logic [LINE_W-1:0]                 i_resp_data,
    output logic [REQ_NUM-1:0]                o_resp_valid,
    output logic [TAG_W-1:0]                  o_resp_tag,
    output logic [LINE_W-1:0]                 o_resp_data,
    output logic [CNT_W-1:0]                  o_outstanding,
    output logic                              o_resp_err
`ifdef MSRH_EXT_ARB_PERF_EN
    ,
    output logic [REQ_NUM-1:0][31:0]          o_perf_grant_cnt,
    output logic [31:0]                       o_perf_stall_cnt
`endif
);

    typedef enum logic { IDLE = 1'b0, SEND = 1'b1 } state_t;

    typedef struct packed {
        ext_cmd_t                 cmd;
        logic [PADDR_W-1:0]       paddr;
        logic [SRC_W+TAG_W-1:0]   tag;
        logic [LINE_W-1:0]        data;
    } slot_t;

    state_t             state_q, state_d;
    slot_t              slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [REQ_NUM-1:0] eligible, grant;
    logic               can_accept, accept;
    logic [SRC_W-1:0]   resp_src;
    logic               resp_src_ok, resp_dec, resp_legal;

    // Acceptance is possible when the slot is empty or drains this cycle.
    // Readies are forced low while reset is asserted.
    assign eligible   = (int'(cnt_q) < MAX_OUTSTANDING) ? i_req_valid : '0;
    assign can_accept = !i_reset && ((state_q == IDLE) || i_ext_ready);
    assign accept     = can_accept && (|eligible);

    msrh_rr_arbiter #(.WIDTH(REQ_NUM)) u_rr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (eligible),
        .i_en    (accept),
        .o_grant (grant)
    );

    assign o_req_ready = can_accept ? grant : '0;

    always_comb begin
        slot_d = slot_q;
        if (accept) begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (grant[i]) begin
                    slot_d.cmd   = ext_cmd_t'(i_req_cmd[i]);
                    slot_d.paddr = i_req_paddr[i];
                    slot_d.tag   = {SRC_W'(i), i_req_tag[i]};
                    slot_d.data  = i_req_data[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (i_ext_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An unsolicited response (nothing outstanding) or one naming a
    // non-existent source is flagged and not forwarded; the count still
    // drops for a bad source id so the bound cannot wedge.
    assign resp_src    = i_resp_tag[SRC_W+TAG_W-1 -: SRC_W];
    assign resp_src_ok = int'(resp_src) < REQ_NUM;
    assign resp_dec    = i_resp_valid && (cnt_q != '0);
    assign resp_legal  = resp_dec && resp_src_ok && !i_reset;

    always_comb begin
        o_resp_valid = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            o_resp_valid[i] = resp_legal && (int'(resp_src) == i);
        end
    end

    assign o_resp_tag  = i_resp_tag[TAG_W-1:0];
    assign o_resp_data = i_resp_data;

    assign cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(resp_dec);
    assign err_d = err_q | (i_resp_valid && (!resp_src_ok || (cnt_q == '0)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_ext_valid   = (state_q == SEND);
    assign o_ext_cmd     = slot_q.cmd;
    assign o_ext_paddr   = slot_q.paddr;
    assign o_ext_tag     = slot_q.tag;
    assign o_ext_data    = slot_q.data;
    assign o_outstanding = cnt_q;
    assign o_resp_err    = err_q;

`ifdef MSRH_EXT_ARB_PERF_EN
    logic [REQ_NUM-1:0][31:0] grant_cnt_q;
    logic [31:0]              stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 32'(o_req_ready[i]);
            end
            if (o_ext_valid && !i_ext_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_perf_grant_cnt = grant_cnt_q;
    assign o_perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_msrh_l1d_ext_arbiter.sv
module tb_msrh_l1d_ext_arbiter;

    localparam int N  = 3;
    localparam int PW = 56;
    localparam int LW = 512;
    localparam int TW = 4;
    localparam int SW = 2;
    localparam int MO = 8;
    localparam int CW = 4;

    logic                    clk;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0]            req_cmd;
    logic [N-1:0][PW-1:0]    req_paddr;
    logic [N-1:0][TW-1:0]    req_tag;
    logic [N-1:0][LW-1:0]    req_data;
    logic                    ext_valid;
    logic                    ext_ready;
    logic                    ext_cmd;
    logic [PW-1:0]           ext_paddr;
    logic [SW+TW-1:0]        ext_tag;
    logic [LW-1:0]           ext_data;
    logic                    resp_valid_in;
    logic [SW+TW-1:0]        resp_tag_in;
    logic [LW-1:0]           resp_data_in;
    logic [N-1:0]            resp_valid;
    logic [TW-1:0]           resp_tag;
    logic [LW-1:0]           resp_data;
    logic [CW-1:0]           outstanding;
    logic                    resp_err;

    msrh_l1d_ext_arbiter dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_cmd     (req_cmd),
        .i_req_paddr   (req_paddr),
        .i_req_tag     (req_tag),
        .i_req_data    (req_data),
        .o_ext_valid   (ext_valid),
        .i_ext_ready   (ext_ready),
        .o_ext_cmd     (ext_cmd),
        .o_ext_paddr   (ext_paddr),
        .o_ext_tag     (ext_tag),
        .o_ext_data    (ext_data),
        .i_resp_valid  (resp_valid_in),
        .i_resp_tag    (resp_tag_in),
        .i_resp_data   (resp_data_in),
        .o_resp_valid  (resp_valid),
        .o_resp_tag    (resp_tag),
        .o_resp_data   (resp_data),
        .o_outstanding (outstanding),
        .o_resp_err    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy, input logic rv, input logic [SW+TW-1:0] rt);
        @(negedge clk);
        req_valid     = v;
        ext_ready     = rdy;
        resp_valid_in = rv;
        resp_tag_in   = rt;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid     = '0;
        ext_ready     = 1'b0;
        resp_valid_in = 1'b0;
        resp_tag_in   = '0;
        resp_data_in  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed per-source fields used by the directed tests.
    task automatic set_fixed_fields();
        logic [TW-1:0] tags [N];
        tags[0] = 4'h3; tags[1] = 4'h5; tags[2] = 4'h9;
        for (int i = 0; i < N; i++) begin
            req_cmd[i]   = (i != 0);
            req_paddr[i] = PW'(56'h1000 + 56'h40 * i);
            req_tag[i]   = tags[i];
            req_data[i]  = {16{32'hA5A50000 + 32'(i)}};
        end
    endtask

    typedef struct {
        logic [N-1:0]     valid;
        logic             rdy;
        logic             rv;
        logic [SW+TW-1:0] rtag;
        logic [N-1:0]     exp_ready;
        logic [N-1:0]     exp_rv;
        int               exp_cnt;
        logic             exp_ev;
        logic [SW+TW-1:0] exp_etag;
    } vec_t;

    vec_t vecs [13];

    // Reference model state
    bit               m_full;
    bit               m_err;
    int               m_ptr;
    int               m_cnt;
    logic             m_cmd;
    logic [PW-1:0]    m_paddr;
    logic [SW+TW-1:0] m_tag;
    logic [LW-1:0]    m_data;
    logic [SW+TW-1:0] inflight [$];
    bit [N-1:0]       pend;

    initial begin
        #200_000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    initial begin
        int winner;
        int rsrc;
        int pick;
        bit legal;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;

        rst = 1'b1;
        clear_inputs();
        req_cmd = '0; req_paddr = '0; req_tag = '0; req_data = '0;
        set_fixed_fields();

        // Reset state
        #2;
        chk("reset_ext_valid", 64'(ext_valid), 64'd0);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_err", 64'(resp_err), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_ext_tag", 64'(ext_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: single load, response, round-robin, stall, drain.
        vecs[0]  = '{3'b001, 1'b1, 1'b0, 6'h00, 3'b001, 3'b000, 1, 1'b1, 6'h03};
        vecs[1]  = '{3'b000, 1'b1, 1'b1, 6'h03, 3'b000, 3'b001, 0, 1'b0, 6'h00};
        vecs[2]  = '{3'b111, 1'b1, 1'b0, 6'h00, 3'b010, 3'b000, 1, 1'b1, 6'h15};
        vecs[3]  = '{3'b111, 1'b1, 1'b0, 6'h00, 3'b100, 3'b000, 2, 1'b1, 6'h29};
        vecs[4]  = '{3'b111, 1'b1, 1'b0, 6'h00, 3'b001, 3'b000, 3, 1'b1, 6'h03};
        vecs[5]  = '{3'b111, 1'b0, 1'b0, 6'h00, 3'b000, 3'b000, 3, 1'b1, 6'h03};
        vecs[6]  = '{3'b111, 1'b0, 1'b0, 6'h00, 3'b000, 3'b000, 3, 1'b1, 6'h03};
        vecs[7]  = '{3'b010, 1'b1, 1'b1, 6'h15, 3'b010, 3'b010, 3, 1'b1, 6'h15};
        vecs[8]  = '{3'b000, 1'b1, 1'b1, 6'h29, 3'b000, 3'b100, 2, 1'b0, 6'h00};
        vecs[9]  = '{3'b000, 1'b0, 1'b1, 6'h03, 3'b000, 3'b001, 1, 1'b0, 6'h00};
        vecs[10] = '{3'b100, 1'b0, 1'b0, 6'h00, 3'b100, 3'b000, 2, 1'b1, 6'h29};
        vecs[11] = '{3'b000, 1'b1, 1'b1, 6'h15, 3'b000, 3'b010, 1, 1'b0, 6'h00};
        vecs[12] = '{3'b000, 1'b0, 1'b1, 6'h03, 3'b000, 3'b001, 0, 1'b0, 6'h00};

        for (int r = 0; r < 13; r++) begin
            drive(vecs[r].valid, vecs[r].rdy, vecs[r].rv, vecs[r].rtag);
            chk($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
            chk($sformatf("tbl%0d_resp_valid", r), 64'(resp_valid), 64'(vecs[r].exp_rv));
            post_edge();
            chk($sformatf("tbl%0d_outstanding", r), 64'(outstanding), 64'(vecs[r].exp_cnt));
            chk($sformatf("tbl%0d_ext_valid", r), 64'(ext_valid), 64'(vecs[r].exp_ev));
            if (vecs[r].exp_ev)
                chk($sformatf("tbl%0d_ext_tag", r), 64'(ext_tag), 64'(vecs[r].exp_etag));
        end
        chk("tbl_err_clear", 64'(resp_err), 64'd0);

        // Outstanding bound, with a same-cycle accept + response at count 5.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(3'b001, 1'b1, 1'b0, 6'h00);
            chk("max_fill_ready", 64'(req_ready), 64'b001);
            post_edge();
            chk("max_fill_cnt", 64'(outstanding), 64'(n + 1));
        end
        drive(3'b001, 1'b1, 1'b1, 6'h03);
        chk("same_cycle_ready", 64'(req_ready), 64'b001);
        chk("same_cycle_resp", 64'(resp_valid), 64'b001);
        post_edge();
        chk("same_cycle_cnt", 64'(outstanding), 64'd5);
        for (int n = 0; n < 3; n++) begin
            drive(3'b001, 1'b1, 1'b0, 6'h00);
            post_edge();
            chk("max_fill2_cnt", 64'(outstanding), 64'(6 + n));
        end
        drive(3'b001, 1'b1, 1'b0, 6'h00);
        chk("max_blocked_ready", 64'(req_ready), 64'b000);
        post_edge();
        chk("max_blocked_cnt", 64'(outstanding), 64'd8);
        chk("max_blocked_ext_valid", 64'(ext_valid), 64'd0);
        drive(3'b001, 1'b1, 1'b1, 6'h03);
        chk("max_resp_ready", 64'(req_ready), 64'b000);
        chk("max_resp_valid", 64'(resp_valid), 64'b001);
        post_edge();
        chk("max_resp_cnt", 64'(outstanding), 64'd7);
        drive(3'b001, 1'b1, 1'b0, 6'h00);
        chk("max_reaccept_ready", 64'(req_ready), 64'b001);
        post_edge();
        chk("max_reaccept_cnt", 64'(outstanding), 64'd8);
        chk("max_reaccept_ext_valid", 64'(ext_valid), 64'd1);

        // Illegal responses: at count 0, and with source id 3.
        do_reset();
        drive(3'b000, 1'b0, 1'b1, 6'h03);
        chk("err_cnt0_resp_valid", 64'(resp_valid), 64'b000);
        post_edge();
        chk("err_cnt0_err", 64'(resp_err), 64'd1);
        chk("err_cnt0_cnt", 64'(outstanding), 64'd0);
        drive(3'b001, 1'b1, 1'b0, 6'h00);
        post_edge();
        chk("err_src3_pre_cnt", 64'(outstanding), 64'd1);
        drive(3'b000, 1'b1, 1'b1, 6'h30);
        chk("err_src3_resp_valid", 64'(resp_valid), 64'b000);
        post_edge();
        chk("err_src3_cnt", 64'(outstanding), 64'd0);
        chk("err_src3_err", 64'(resp_err), 64'd1);
        drive(3'b000, 1'b0, 1'b0, 6'h00);
        post_edge();
        chk("err_sticky", 64'(resp_err), 64'd1);

        // Asynchronous reset in the middle of a SEND cycle.
        drive(3'b001, 1'b0, 1'b0, 6'h00);
        chk("arst_accept_ready", 64'(req_ready), 64'b001);
        post_edge();
        chk("arst_pre_ext_valid", 64'(ext_valid), 64'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ext_valid", 64'(ext_valid), 64'd0);
        chk("arst_cnt", 64'(outstanding), 64'd0);
        chk("arst_err", 64'(resp_err), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_ext_paddr", 64'(ext_paddr), 64'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;

        // Randomized traffic against the reference model.
        m_full = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
        m_cmd = 0; m_paddr = '0; m_tag = '0; m_data = '0;
        pend = '0;
        inflight.delete();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2 == 1)) begin
                    pend[i]      = 1'b1;
                    req_cmd[i]   = 1'($urandom);
                    req_paddr[i] = PW'({$urandom, $urandom});
                    req_tag[i]   = TW'($urandom);
                    for (int w = 0; w < LW / 32; w++) req_data[i][w*32 +: 32] = $urandom;
                end
            end
            req_valid = pend;
            ext_ready = ($urandom % 4 != 0);
            resp_valid_in = 1'b0;
            resp_tag_in   = '0;
            if (inflight.size() > 0 && ($urandom % 3 == 0)) begin
                pick = int'($urandom % inflight.size());
                resp_valid_in = 1'b1;
                resp_tag_in   = inflight[pick];
                inflight.delete(pick);
            end else if ($urandom % 97 == 0) begin
                resp_valid_in = 1'b1;
                resp_tag_in   = {2'b11, 4'($urandom)};
            end
            for (int w = 0; w < LW / 32; w++) resp_data_in[w*32 +: 32] = $urandom;
            #1;

            winner = -1;
            if (!m_full || ext_ready) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (winner < 0 && pend[idx] && m_cnt < MO) winner = idx;
                end
            end
            exp_rdy = (winner >= 0) ? N'(1 << winner) : '0;
            rsrc    = int'(resp_tag_in[SW+TW-1:TW]);
            legal   = resp_valid_in && (m_cnt > 0) && (rsrc < N);
            exp_rv  = legal ? N'(1 << rsrc) : '0;

            chk("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_resp_valid", 64'(resp_valid), 64'(exp_rv));
            if (legal) begin
                chk("rnd_resp_tag", 64'(resp_tag), 64'(resp_tag_in[TW-1:0]));
                chkw("rnd_resp_data", resp_data, resp_data_in);
            end
            chk("rnd_ext_valid", 64'(ext_valid), 64'(m_full));
            chk("rnd_outstanding", 64'(outstanding), 64'(m_cnt));
            chk("rnd_err", 64'(resp_err), 64'(m_err));
            if (m_full) begin
                chk("rnd_ext_cmd", 64'(ext_cmd), 64'(m_cmd));
                chk("rnd_ext_paddr", 64'(ext_paddr), 64'(m_paddr));
                chk("rnd_ext_tag", 64'(ext_tag), 64'(m_tag));
                chkw("rnd_ext_data", ext_data, m_data);
            end

            if (resp_valid_in && (m_cnt == 0 || rsrc >= N)) m_err = 1;
            m_cnt = m_cnt - ((resp_valid_in && m_cnt > 0) ? 1 : 0);
            if (winner >= 0) begin
                m_full  = 1;
                m_cmd   = req_cmd[winner];
                m_paddr = req_paddr[winner];
                m_tag   = {SW'(winner), req_tag[winner]};
                m_data  = req_data[winner];
                m_ptr   = (winner + 1) % N;
                m_cnt   = m_cnt + 1;
                inflight.push_back(m_tag);
                pend[winner] = 1'b0;
            end else if (m_full && ext_ready) begin
                m_full = 0;
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
